// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use stalls,
// branch/jump flushes, EX operand forwarding and saturating bring-up event counters.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_jump,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             regwrite;
    logic             memread;
  } slot_t;

  slot_t            ex_q, ex_d, mem_q, wb_q;
  logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic             ex_uses_rt_q, ex_uses_rt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic luh;
  logic stall_evt;
  logic flush_evt;

  // A slot can only supply a value if it is a live register-writing instruction
  // targeting a non-zero register that matches the EX source.
  function automatic logic slot_hit(slot_t s, logic [REG_W-1:0] src);
    return s.valid && s.regwrite && (s.dst != '0) && (s.dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(slot_t mem_s, slot_t wb_s,
                                         logic [REG_W-1:0] src, logic used);
    if (!used)                       return 2'b00;
    else if (slot_hit(mem_s, src))   return 2'b10;
    else if (slot_hit(wb_s, src))    return 2'b01;
    else                             return 2'b00;
  endfunction

  assign luh = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.dst != '0) &&
               ((ex_q.dst == id_rs) || ((ex_q.dst == id_rt) && id_uses_rt));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_evt   = 1'b1;
    end else if (luh) begin
      // Holding PC and IF/ID re-presents the ID instruction (and any jump) next cycle.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_evt   = 1'b1;
    end else if (id_jump) begin
      ifid_flush  = 1'b1;
      flush_evt   = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset && ex_q.valid) begin
      fwd_a = fwd_sel(mem_q, wb_q, ex_rs_q, 1'b1);
      fwd_b = fwd_sel(mem_q, wb_q, ex_rt_q, ex_uses_rt_q);
    end
  end

  always_comb begin
    ex_d         = '0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_uses_rt_d = 1'b0;
    if (!idex_bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.dst      = id_dst;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_rs_d       = id_rs;
      ex_rt_d       = id_rt;
      ex_uses_rt_d  = id_uses_rt;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_uses_rt_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      wb_q         <= mem_q;
      mem_q        <= ex_q;
      ex_q         <= ex_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_uses_rt_q <= ex_uses_rt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan scenarios plus
// randomized traffic compared against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, id_dst;
  logic             id_uses_rt, id_regwrite, id_memread, id_jump, ex_branch_taken;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Instruction-level model: one record per in-flight instruction, index 0=EX, 1=MEM, 2=WB.
  typedef struct {
    bit valid;
    int dst;
    bit rw;
    bit mr;
    int rs;
    int rt;
    bit urt;
  } instr_t;

  instr_t pipe_m[3];
  int     stall_m = 0;
  int     flush_m = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(instr_t i, int r);
    return i.valid && i.rw && r != 0 && i.dst == r;
  endfunction

  function automatic int src_sel(int r, bit used);
    if (reset || !pipe_m[0].valid || !used) return 0;
    if (writes(pipe_m[1], r)) return 2;
    if (writes(pipe_m[2], r)) return 1;
    return 0;
  endfunction

  function automatic bit load_use();
    instr_t e = pipe_m[0];
    return e.valid && e.mr && writes(e, int'(id_rs)) ||
           e.valid && e.mr && id_uses_rt && writes(e, int'(id_rt));
  endfunction

  // One clock period: compare every output at the falling edge, then advance the model.
  task automatic cycle();
    string kind;
    instr_t nxt;
    @(negedge clk);
    if (reset)                kind = "reset";
    else if (ex_branch_taken) kind = "branch";
    else if (load_use())      kind = "stall";
    else if (id_jump)         kind = "jump";
    else                      kind = "run";
    check({kind, ".pc_write"},    int'(pc_write),    (kind == "reset" || kind == "stall") ? 0 : 1);
    check({kind, ".ifid_write"},  int'(ifid_write),  (kind == "reset" || kind == "stall") ? 0 : 1);
    check({kind, ".ifid_flush"},  int'(ifid_flush),  (kind == "reset" || kind == "branch" || kind == "jump") ? 1 : 0);
    check({kind, ".idex_bubble"}, int'(idex_bubble), (kind == "reset" || kind == "branch" || kind == "stall") ? 1 : 0);
    check({kind, ".fwd_a"},       int'(fwd_a),       src_sel(pipe_m[0].rs, 1'b1));
    check({kind, ".fwd_b"},       int'(fwd_b),       src_sel(pipe_m[0].rt, pipe_m[0].urt));
    check({kind, ".stall_cnt"},   int'(stall_cnt),   stall_m);
    check({kind, ".flush_cnt"},   int'(flush_cnt),   flush_m);
    @(posedge clk);
    if (kind == "reset") begin
      foreach (pipe_m[i]) pipe_m[i] = '{default: 0};
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (kind == "stall" && stall_m < CMAX) stall_m++;
      if ((kind == "branch" || kind == "jump") && flush_m < CMAX) flush_m++;
      nxt = '{valid: 1, dst: int'(id_dst), rw: id_regwrite, mr: id_memread,
              rs: int'(id_rs), rt: int'(id_rt), urt: id_uses_rt};
      if (kind == "branch" || kind == "stall") nxt = '{default: 0};
      pipe_m[2] = pipe_m[1];
      pipe_m[1] = pipe_m[0];
      pipe_m[0] = nxt;
    end
    #1;
  endtask

  task automatic drive(input int rs, input int rt, input bit urt, input int dst,
                       input bit rw, input bit mr, input bit jmp, input bit br);
    id_rs           = REG_W'(rs);
    id_rt           = REG_W'(rt);
    id_uses_rt      = urt;
    id_dst          = REG_W'(dst);
    id_regwrite     = rw;
    id_memread      = mr;
    id_jump         = jmp;
    ex_branch_taken = br;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (pipe_m[i]) pipe_m[i] = '{default: 0};
    reset = 1'b1;
    nop();
    repeat (3) cycle();
    reset = 1'b0;
    #1;
    check("rel.pc_write", int'(pc_write), 1);
    check("rel.fwd_a", int'(fwd_a), 0);
    check("rel.stall_cnt", int'(stall_cnt), 0);
    cycle();

    // lw $8,0($1) then add $9,$8,$1: one stall, then WB forwarding on rs.
    drive(1, 8, 0, 8, 1, 1, 0, 0); cycle();
    drive(8, 1, 1, 9, 1, 0, 0, 0); #1;
    check("luh.pc_write", int'(pc_write), 0);
    cycle();
    check("luh.stall_cnt", int'(stall_cnt), 1);
    check("luh.released", int'(pc_write), 1);
    cycle();
    nop(); #1;
    check("luh.fwd_a_wb", int'(fwd_a), 1);
    cycle(); cycle(); cycle();

    // add $3,$1,$2 ; sub $4,$3,$3 back to back -> both from EX/MEM.
    drive(1, 2, 1, 3, 1, 0, 0, 0); cycle();
    drive(3, 3, 1, 4, 1, 0, 0, 0); cycle();
    nop(); #1;
    check("b2b.fwd_a", int'(fwd_a), 2);
    check("b2b.fwd_b", int'(fwd_b), 2);
    cycle();
    // Same pair with a nop between -> both from MEM/WB.
    drive(1, 2, 1, 3, 1, 0, 0, 0); cycle();
    nop(); cycle();
    drive(3, 3, 1, 4, 1, 0, 0, 0); cycle();
    nop(); #1;
    check("gap.fwd_a", int'(fwd_a), 1);
    check("gap.fwd_b", int'(fwd_b), 1);
    cycle();

    // Writes to $0 are never forwarded and never stall.
    drive(1, 2, 1, 0, 1, 1, 0, 0); cycle();
    drive(0, 0, 1, 5, 1, 0, 0, 0); #1;
    check("r0.no_stall", int'(pc_write), 1);
    cycle();
    nop(); #1;
    check("r0.fwd_a", int'(fwd_a), 0);
    check("r0.fwd_b", int'(fwd_b), 0);
    cycle(); cycle(); cycle();

    // Branch taken together with luh and jump: branch wins.
    drive(1, 2, 0, 7, 1, 1, 0, 0); cycle();
    drive(7, 7, 1, 6, 1, 0, 1, 1); #1;
    check("br.idex_bubble", int'(idex_bubble), 1);
    check("br.pc_write", int'(pc_write), 1);
    cycle();
    check("br.stall_cnt", int'(stall_cnt), 1);

    // Flush counter saturates at all-ones.
    repeat (CMAX + 8) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      cycle();
    end
    check("sat.flush_cnt", int'(flush_cnt), CMAX);

    // Reset in the middle of a stall wipes counters and slots.
    drive(1, 2, 0, 9, 1, 1, 0, 0); cycle();
    drive(9, 0, 0, 3, 1, 0, 1, 0); #1;
    check("mid.stall", int'(pc_write), 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check("mid.flush_cnt", int'(flush_cnt), 0);
    check("mid.no_stall", int'(pc_write), 1);
    check("mid.fwd_a", int'(fwd_a), 0);
    cycle();

    // Randomized traffic on a small register range to provoke every rule.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 9) == 0));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
